// File: rtl/serial_slave_port.sv
// serial_slave_port
// Bit-serial slave with a small local memory. A transaction is one mode bit,
// sampled with the first address bit, followed by ADDR_WIDTH address bits MSB
// first. A write then takes DATA_WIDTH data bits. A read waits READ_LATENCY
// cycles and then returns DATA_WIDTH bits on rd_bus under a valid/ready
// handshake. Every output comes straight from a flop. Each output flop is
// loaded from the next-state value, so it always matches the current state.

module serial_slave_port #(
  parameter int ADDR_WIDTH     = 12,
  parameter int MEM_ADDR_WIDTH = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int READ_LATENCY   = 2,
  parameter bit SPLIT_EN       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic mode,
  input  logic wr_bus,
  input  logic master_valid,
  output logic slave_ready,
  output logic rd_bus,
  output logic slave_valid,
  input  logic master_ready,
  output logic split
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WDATA = 3'd2,
    WDONE = 3'd3,
    RWAIT = 3'd4,
    RDATA = 3'd5
  } state_t;

  // One counter serves both the address phase and the data phases.
  localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_W = $clog2(MAX_W + 1);
  localparam int LAT_W = $clog2(READ_LATENCY + 1);
  localparam int MEM_DEPTH = 2 ** MEM_ADDR_WIDTH;

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [LAT_W-1:0] LAT_ZERO  = {LAT_W{1'b0}};
  localparam logic [LAT_W-1:0] LAT_ONE   = LAT_W'(1);
  localparam logic [LAT_W-1:0] LAT_INIT  = LAT_W'(READ_LATENCY - 1);

  localparam logic [MEM_ADDR_WIDTH-1:0] ADDR_ZERO = {MEM_ADDR_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0]     DATA_ZERO = {DATA_WIDTH{1'b0}};

  state_t state_r, state_next;

  logic                      mode_r, mode_next;
  // Only the low address bits are kept. The upper bits fall off the shift
  // register, which gives the modulo-2^MEM_ADDR_WIDTH aliasing.
  logic [MEM_ADDR_WIDTH-1:0] addr_r, addr_next;
  logic [DATA_WIDTH-1:0]     data_r, data_next;
  logic [DATA_WIDTH-1:0]     rd_r, rd_next;
  logic [CNT_W-1:0]          bit_cnt_r, bit_cnt_next;
  logic [LAT_W-1:0]          lat_cnt_r, lat_cnt_next;

  logic                      xfer_s;
  logic                      mem_we_s;
  logic [DATA_WIDTH-1:0]     mem_wdata_s;
  logic [DATA_WIDTH-1:0]     mem_rdata_s;

  logic                      ready_s;
  logic                      valid_s;
  logic                      rd_bit_s;
  logic                      split_s;

  // Local storage. It has no reset, so its contents survive rst.
  logic [DATA_WIDTH-1:0] mem [0:MEM_DEPTH-1];

  assign xfer_s      = master_valid & slave_ready;
  assign mem_wdata_s = (data_r << 1'b1) | DATA_WIDTH'(wr_bus);
  assign mem_rdata_s = mem[addr_r];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // Next-state decode. Stalls hold the current state.
  always_comb begin
    state_next = state_r;
    case (state_r)
      IDLE: begin
        if (xfer_s) begin
          if (ADDR_LAST == CNT_ZERO) begin
            state_next = mode ? WDATA : RWAIT;
          end else begin
            state_next = ADDR;
          end
        end else begin
          state_next = IDLE;
        end
      end
      ADDR: begin
        if (xfer_s && (bit_cnt_r == ADDR_LAST)) begin
          state_next = mode_r ? WDATA : RWAIT;
        end else begin
          state_next = ADDR;
        end
      end
      WDATA: begin
        if (xfer_s && (bit_cnt_r == DATA_LAST)) begin
          state_next = WDONE;
        end else begin
          state_next = WDATA;
        end
      end
      WDONE: begin
        state_next = IDLE;
      end
      RWAIT: begin
        if (lat_cnt_r == LAT_ZERO) begin
          state_next = RDATA;
        end else begin
          state_next = RWAIT;
        end
      end
      RDATA: begin
        if (master_ready && (bit_cnt_r == DATA_LAST)) begin
          state_next = IDLE;
        end else begin
          state_next = RDATA;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath next values: shift registers, bit/latency counters, memory write strobe.
  always_comb begin
    mode_next    = mode_r;
    addr_next    = addr_r;
    data_next    = data_r;
    rd_next      = rd_r;
    bit_cnt_next = bit_cnt_r;
    lat_cnt_next = lat_cnt_r;
    mem_we_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (xfer_s) begin
          mode_next = mode;
          addr_next = MEM_ADDR_WIDTH'(wr_bus);
          data_next = DATA_ZERO;
          if (ADDR_LAST == CNT_ZERO) begin
            bit_cnt_next = CNT_ZERO;
            lat_cnt_next = LAT_INIT;
          end else begin
            bit_cnt_next = CNT_ONE;
          end
        end else begin
          mode_next = mode_r;
        end
      end
      ADDR: begin
        if (xfer_s) begin
          addr_next = (addr_r << 1'b1) | MEM_ADDR_WIDTH'(wr_bus);
          if (bit_cnt_r == ADDR_LAST) begin
            bit_cnt_next = CNT_ZERO;
            lat_cnt_next = LAT_INIT;
          end else begin
            bit_cnt_next = bit_cnt_r + CNT_ONE;
          end
        end else begin
          addr_next = addr_r;
        end
      end
      WDATA: begin
        if (xfer_s) begin
          data_next = mem_wdata_s;
          if (bit_cnt_r == DATA_LAST) begin
            mem_we_s     = 1'b1;
            bit_cnt_next = CNT_ZERO;
          end else begin
            bit_cnt_next = bit_cnt_r + CNT_ONE;
          end
        end else begin
          data_next = data_r;
        end
      end
      WDONE: begin
        data_next = DATA_ZERO;
      end
      RWAIT: begin
        if (lat_cnt_r == LAT_ZERO) begin
          rd_next      = mem_rdata_s;
          bit_cnt_next = CNT_ZERO;
        end else begin
          lat_cnt_next = lat_cnt_r - LAT_ONE;
        end
      end
      RDATA: begin
        if (master_ready) begin
          rd_next = rd_r << 1'b1;
          if (bit_cnt_r == DATA_LAST) begin
            bit_cnt_next = CNT_ZERO;
          end else begin
            bit_cnt_next = bit_cnt_r + CNT_ONE;
          end
        end else begin
          rd_next = rd_r;
        end
      end
      default: begin
        bit_cnt_next = CNT_ZERO;
        lat_cnt_next = LAT_ZERO;
      end
    endcase
  end

  // Datapath registers. They are cleared on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_r    <= 1'b0;
      addr_r    <= ADDR_ZERO;
      data_r    <= DATA_ZERO;
      rd_r      <= DATA_ZERO;
      bit_cnt_r <= CNT_ZERO;
      lat_cnt_r <= LAT_ZERO;
    end else begin
      mode_r    <= mode_next;
      addr_r    <= addr_next;
      data_r    <= data_next;
      rd_r      <= rd_next;
      bit_cnt_r <= bit_cnt_next;
      lat_cnt_r <= lat_cnt_next;
    end
  end

  // Memory write port. It is written only on the edge that accepts the last data bit.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[addr_r] <= mem_wdata_s;
    end
  end

  // Output decode from the next state, so each output flop matches the new state.
  always_comb begin
    ready_s  = 1'b0;
    valid_s  = 1'b0;
    rd_bit_s = 1'b0;
    split_s  = 1'b0;
    case (state_next)
      IDLE, ADDR, WDATA: begin
        ready_s = 1'b1;
      end
      WDONE: begin
        ready_s = 1'b0;
      end
      RWAIT: begin
        split_s = SPLIT_EN;
      end
      RDATA: begin
        valid_s  = 1'b1;
        rd_bit_s = rd_next[DATA_WIDTH-1];
      end
      default: begin
        ready_s = 1'b0;
      end
    endcase
  end

  // Output registers. Reset leaves them in the IDLE configuration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slave_ready <= 1'b1;
      slave_valid <= 1'b0;
      rd_bus      <= 1'b0;
      split       <= 1'b0;
    end else begin
      slave_ready <= ready_s;
      slave_valid <= valid_s;
      rd_bus      <= rd_bit_s;
      split       <= split_s;
    end
  end

endmodule

// File: tb/tb_serial_slave_port.sv
// Directed testbench for serial_slave_port. Inputs change 1 time unit after
// the rising edge, and outputs are sampled at that same point.

module tb_serial_slave_port;

  logic clk = 1'b0;
  logic rst, mode, wr_bus, master_valid, master_ready;
  logic slave_ready, rd_bus, slave_valid, split;
  logic s_mode, s_wr, s_mv, s_mr;
  logic s_ready, s_rd, s_valid, s_split;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_slave_port dut (
    .clk(clk), .rst(rst), .mode(mode), .wr_bus(wr_bus),
    .master_valid(master_valid), .slave_ready(slave_ready),
    .rd_bus(rd_bus), .slave_valid(slave_valid),
    .master_ready(master_ready), .split(split)
  );

  serial_slave_port #(.READ_LATENCY(4), .SPLIT_EN(1'b1)) dut_s (
    .clk(clk), .rst(rst), .mode(s_mode), .wr_bus(s_wr),
    .master_valid(s_mv), .slave_ready(s_ready),
    .rd_bus(s_rd), .slave_valid(s_valid),
    .master_ready(s_mr), .split(s_split)
  );

  // Drive-only helpers
  task automatic send_addr(input logic m_first, input logic m_rest, input logic [11:0] a);
    for (int i = 11; i >= 0; i--) begin
      mode = (i == 11) ? m_first : m_rest;
      wr_bus = a[i];
      master_valid = 1'b1;
      @(posedge clk); #1;
    end
    master_valid = 1'b0;
    wr_bus = 1'b0;
  endtask

  task automatic send_data(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) begin
      wr_bus = d[i];
      master_valid = 1'b1;
      @(posedge clk); #1;
    end
    master_valid = 1'b0;
    wr_bus = 1'b0;
  endtask

  task automatic write_txn(input logic [11:0] a, input logic [7:0] d);
    send_addr(1'b1, 1'b1, a);
    send_data(d);
    @(posedge clk); #1;
  endtask

  task automatic read_txn(input logic [11:0] a, input logic m_rest,
                          output logic [7:0] d, output int lat, output bit tmo);
    send_addr(1'b0, m_rest, a);
    d = 8'h00;
    lat = 0;
    tmo = 1'b0;
    master_ready = 1'b1;
    while (!slave_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!slave_valid) begin
      tmo = 1'b1;
    end else begin
      for (int i = 0; i < 8; i++) begin
        d = {d[6:0], rd_bus};
        @(posedge clk); #1;
      end
    end
    master_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (slave_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", slave_ready); end
    total++; if (slave_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", slave_valid); end
    total++; if (rd_bus !== 1'b0) begin bad++; $display("FAIL reset_rd_bus: got %b want 0", rd_bus); end
    total++; if (split !== 1'b0) begin bad++; $display("FAIL reset_split: got %b want 0", split); end
    total++; if (s_split !== 1'b0) begin bad++; $display("FAIL reset_s_split: got %b want 0", s_split); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    logic [7:0] exp;
    logic [11:0] a;
    int lat;
    exp = 8'hA5;
    a = 12'h012;
    send_addr(1'b1, 1'b1, a);
    send_data(exp);
    total++; if (slave_ready !== 1'b0) begin bad++; $display("FAIL wr_wdone_ready: got %b want 0", slave_ready); end
    @(posedge clk); #1;
    total++; if (slave_ready !== 1'b1) begin bad++; $display("FAIL wr_idle_ready: got %b want 1", slave_ready); end
    send_addr(1'b0, 1'b0, a);
    total++; if ({slave_ready, slave_valid, rd_bus, split} !== 4'b0000)
      begin bad++; $display("FAIL rwait_outputs: got %b want 0000", {slave_ready, slave_valid, rd_bus, split}); end
    master_ready = 1'b1;
    lat = 0;
    while (!slave_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    total++; if (lat != 2) begin bad++; $display("FAIL read_latency: got %0d want 2", lat); end
    for (int i = 7; i >= 0; i--) begin
      total++; if ({slave_valid, rd_bus} !== {1'b1, exp[i]})
        begin bad++; $display("FAIL read_bit%0d: got v=%b d=%b want v=1 d=%b", i, slave_valid, rd_bus, exp[i]); end
      @(posedge clk); #1;
    end
    master_ready = 1'b0;
    total++; if ({slave_valid, rd_bus} !== 2'b00) begin bad++; $display("FAIL read_end: got %b want 00", {slave_valid, rd_bus}); end
  endtask

  task automatic test_alias();
    logic [7:0] d;
    int lat;
    bit tmo;
    write_txn(12'hF34, 8'h3C);
    read_txn(12'h034, 1'b0, d, lat, tmo);
    total++; if (tmo || d !== 8'h3C) begin bad++; $display("FAIL alias_read034: got %h tmo=%b want 3c", d, tmo); end
    write_txn(12'h534, 8'hC7);
    read_txn(12'hF34, 1'b0, d, lat, tmo);
    total++; if (tmo || d !== 8'hC7) begin bad++; $display("FAIL alias_readF34: got %h tmo=%b want c7", d, tmo); end
  endtask

  task automatic test_stall();
    logic [11:0] a;
    logic [7:0] exp, d;
    int lat;
    a = 12'h0AB;
    exp = 8'h5A;
    for (int i = 11; i >= 6; i--) begin
      mode = 1'b1; wr_bus = a[i]; master_valid = 1'b1;
      @(posedge clk); #1;
    end
    master_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wr_bus = ~wr_bus;
      mode = 1'b0;
      @(posedge clk); #1;
      total++; if (slave_ready !== 1'b1) begin bad++; $display("FAIL addr_stall_ready%0d: got %b want 1", k, slave_ready); end
    end
    for (int i = 5; i >= 0; i--) begin
      wr_bus = a[i]; master_valid = 1'b1;
      @(posedge clk); #1;
    end
    master_valid = 1'b0;
    send_data(exp);
    @(posedge clk); #1;
    send_addr(1'b0, 1'b0, a);
    master_ready = 1'b1;
    lat = 0;
    while (!slave_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    d = 8'h00;
    for (int i = 7; i >= 5; i--) begin
      d = {d[6:0], rd_bus};
      @(posedge clk); #1;
    end
    master_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      total++; if ({slave_valid, rd_bus} !== {1'b1, exp[4]})
        begin bad++; $display("FAIL rd_stall%0d: got v=%b d=%b want v=1 d=%b", k, slave_valid, rd_bus, exp[4]); end
    end
    master_ready = 1'b1;
    for (int i = 4; i >= 0; i--) begin
      d = {d[6:0], rd_bus};
      @(posedge clk); #1;
    end
    master_ready = 1'b0;
    total++; if (d !== exp) begin bad++; $display("FAIL stall_data: got %h want %h", d, exp); end
    total++; if (slave_valid !== 1'b0) begin bad++; $display("FAIL stall_end_valid: got %b want 0", slave_valid); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d, partial;
    int lat;
    bit tmo;
    partial = 8'hEE;
    write_txn(12'h020, 8'h11);
    send_addr(1'b1, 1'b1, 12'h020);
    for (int i = 7; i >= 3; i--) begin
      wr_bus = partial[i]; master_valid = 1'b1;
      @(posedge clk); #1;
    end
    master_valid = 1'b0;
    rst = 1'b1;
    #2;
    total++; if ({slave_ready, slave_valid, rd_bus, split} !== 4'b1000)
      begin bad++; $display("FAIL rst_mid_write: got %b want 1000", {slave_ready, slave_valid, rd_bus, split}); end
    @(posedge clk); #1;
    rst = 1'b0;
    read_txn(12'h020, 1'b0, d, lat, tmo);
    total++; if (tmo || d !== 8'h11) begin bad++; $display("FAIL rst_mem_kept: got %h tmo=%b want 11", d, tmo); end
    send_addr(1'b0, 1'b0, 12'h020);
    master_ready = 1'b1;
    lat = 0;
    while (!slave_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    total++; if ({slave_ready, slave_valid, rd_bus} !== 3'b100)
      begin bad++; $display("FAIL rst_mid_read: got %b want 100", {slave_ready, slave_valid, rd_bus}); end
    @(posedge clk); #1;
    rst = 1'b0;
    master_ready = 1'b0;
    read_txn(12'h020, 1'b0, d, lat, tmo);
    total++; if (tmo || d !== 8'h11) begin bad++; $display("FAIL rst_read_again: got %h tmo=%b want 11", d, tmo); end
  endtask

  task automatic test_mode_latch();
    logic [7:0] d;
    int lat;
    bit tmo;
    send_addr(1'b1, 1'b0, 12'h077);
    send_data(8'h3E);
    @(posedge clk); #1;
    read_txn(12'h077, 1'b1, d, lat, tmo);
    total++; if (tmo || d !== 8'h3E) begin bad++; $display("FAIL mode_latch: got %h tmo=%b want 3e", d, tmo); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    int lat;
    bit tmo;
    send_addr(1'b1, 1'b1, 12'h0C3);
    send_data(8'h96);
    total++; if (slave_ready !== 1'b0) begin bad++; $display("FAIL b2b_wdone_ready: got %b want 0", slave_ready); end
    mode = 1'b1; wr_bus = 1'b1; master_valid = 1'b1;
    @(posedge clk); #1;
    total++; if (slave_ready !== 1'b1) begin bad++; $display("FAIL b2b_idle_ready: got %b want 1", slave_ready); end
    read_txn(12'h0C3, 1'b0, d, lat, tmo);
    total++; if (tmo || d !== 8'h96 || lat != 2) begin bad++; $display("FAIL b2b_read: got %h lat=%0d want 96 lat=2", d, lat); end
    total++; if ({slave_valid, slave_ready} !== 2'b01) begin bad++; $display("FAIL b2b_after_read: got %b want 01", {slave_valid, slave_ready}); end
    write_txn(12'h0C4, 8'h69);
    read_txn(12'h0C4, 1'b0, d, lat, tmo);
    total++; if (tmo || d !== 8'h69) begin bad++; $display("FAIL b2b_write_after_read: got %h want 69", d); end
  endtask

  task automatic test_split();
    logic [11:0] a;
    logic [7:0] exp, d;
    int cnt, guard;
    a = 12'h005;
    exp = 8'hC3;
    for (int i = 11; i >= 0; i--) begin
      s_mode = 1'b1; s_wr = a[i]; s_mv = 1'b1;
      @(posedge clk); #1;
    end
    for (int i = 7; i >= 0; i--) begin
      s_wr = exp[i];
      @(posedge clk); #1;
    end
    s_mv = 1'b0;
    @(posedge clk); #1;
    for (int i = 11; i >= 0; i--) begin
      s_mode = 1'b0; s_wr = a[i]; s_mv = 1'b1;
      @(posedge clk); #1;
    end
    s_mv = 1'b0;
    s_mr = 1'b1;
    cnt = 0;
    guard = 0;
    while (!s_valid && guard < 20) begin
      if (s_split) cnt++;
      @(posedge clk); #1;
      guard++;
    end
    total++; if (cnt != 4 || !s_valid) begin bad++; $display("FAIL split_cycles: got %0d valid=%b want 4", cnt, s_valid); end
    total++; if (s_split !== 1'b0) begin bad++; $display("FAIL split_in_rdata: got %b want 0", s_split); end
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      d = {d[6:0], s_rd};
      @(posedge clk); #1;
    end
    s_mr = 1'b0;
    total++; if (d !== exp) begin bad++; $display("FAIL split_data: got %h want %h", d, exp); end
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; wr_bus = 1'b0; master_valid = 1'b0; master_ready = 1'b0;
    s_mode = 1'b0; s_wr = 1'b0; s_mv = 1'b0; s_mr = 1'b0;
    test_reset();
    test_write_read();
    test_alias();
    test_stall();
    test_reset_mid();
    test_mode_latch();
    test_back_to_back();
    test_split();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_slave_port.md
SERIAL_SLAVE_PORT -- requirements
Module: serial_slave_port

Interface
REQ-001 The module SHALL have parameter ADDR_WIDTH, default 12, giving the number of serial address bits received per transaction.
REQ-002 The module SHALL have parameter MEM_ADDR_WIDTH, default 8, giving the number of address LSBs that index the local memory (MEM_ADDR_WIDTH <= ADDR_WIDTH).
REQ-003 The module SHALL have parameter DATA_WIDTH, default 8, giving the number of serial data bits per transaction.
REQ-004 The module SHALL have parameter READ_LATENCY, default 2 (minimum 1), giving the number of wait cycles between the last address bit and read data.
REQ-005 The module SHALL have parameter SPLIT_EN, default 0, which when 1 asserts split during the read wait.
REQ-006 clk  input  1  sole clock; all state changes on rising edge.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 mode  input  1  transaction type, 1 = write and 0 = read; sampled with the first address bit.
REQ-009 wr_bus  input  1  serial address/write-data bit, MSB first.
REQ-010 master_valid  input  1  wr_bus bit valid this cycle.
REQ-011 slave_ready  output  1  slave accepts a wr_bus bit this cycle.
REQ-012 rd_bus  output  1  serial read-data bit, MSB first.
REQ-013 slave_valid  output  1  rd_bus bit valid this cycle.
REQ-014 master_ready  input  1  master consumes the rd_bus bit this cycle.
REQ-015 split  output  1  slave is busy in the read wait (only when SPLIT_EN = 1).

Function
REQ-016 The slave SHALL treat a bit as transferred only on a rising edge where master_valid && slave_ready; master_valid low SHALL stall the current phase with no state change.
REQ-017 The FSM states SHALL be IDLE, ADDR, WDATA, WDONE, RWAIT and RDATA.
REQ-018 slave_ready SHALL be 1 in IDLE, ADDR and WDATA, and 0 in WDONE, RWAIT and RDATA.
REQ-019 IDLE: on a transfer, the slave SHALL latch mode, shift in address bit 1 of ADDR_WIDTH, and go to ADDR.
REQ-020 ADDR: the slave SHALL shift in the remaining address bits MSB first; on the ADDR_WIDTH-th bit it SHALL go to WDATA if mode=1, else to RWAIT.
REQ-021 WDATA: the slave SHALL shift in DATA_WIDTH bits MSB first; on the edge accepting the last bit, it SHALL write mem[addr[MEM_ADDR_WIDTH-1:0]] and go to WDONE.
REQ-022 WDONE: the slave SHALL stay exactly 1 cycle, then go to IDLE.
REQ-023 Address bits above MEM_ADDR_WIDTH SHALL be ignored, so addresses alias modulo 2^MEM_ADDR_WIDTH.
REQ-024 RWAIT: the slave SHALL stay READ_LATENCY cycles, counted by a down-counter, and load the read shift register from memory on the final cycle.
- Transitions to RDATA.
- split = SPLIT_EN throughout RWAIT, and 0 in all other states.
REQ-025 RDATA: slave_valid SHALL be 1 and rd_bus SHALL equal the shift-register MSB.
- The register shifts on each edge where master_ready = 1.
- After DATA_WIDTH consumed bits, returns to IDLE; slave_valid is 0 in the following cycle.
REQ-026 master_ready low in RDATA SHALL hold rd_bus and the bit count unchanged.
REQ-027 Outside RDATA, rd_bus and slave_valid SHALL be 0.
REQ-028 master_valid and wr_bus SHALL be ignored in WDONE, RWAIT and RDATA.
REQ-029 mode changes after the first address bit SHALL be ignored for the rest of the transaction.
REQ-030 Back-to-back: a transfer in the cycle after WDONE or RDATA completion SHALL start a new transaction from IDLE with no extra bubble.

Reset
REQ-031 On rst=1, regardless of the clock and mid-transaction, the slave SHALL:
- go to IDLE;
- clear the shift registers, bit counters and latency counter;
- set slave_valid=0, rd_bus=0 and split=0, with slave_ready=1 (IDLE).
REQ-032 Memory contents SHALL NOT be reset or modified by rst, and a write interrupted by reset before its last data bit SHALL leave memory unchanged.

Verification
REQ-033 Write then read: write 0xA5 to address 0x012, then read 0x012 -> after 2 RWAIT cycles rd_bus serializes 1,0,1,0,0,1,0,1 with slave_valid=1 for 8 cycles.
REQ-034 Stall: master_valid low for 3 cycles mid-address and master_ready low for 2 cycles mid-read -> the transaction completes with correct data and the bit counts unchanged during the stalls.
REQ-035 Alias: write 0x3C to address 0xF34, then read 0x034 -> returns 0x3C.
REQ-036 Reset mid-write: apply rst after 5 of 8 data bits to address 0x020 (previously 0x11), then read 0x020 -> returns 0x11; after rst, slave_ready=1 and slave_valid=0.
REQ-037 Split: with SPLIT_EN=1 and READ_LATENCY=4 -> split=1 for exactly 4 cycles before the first slave_valid; with SPLIT_EN=0, split stays 0.
REQ-038 Back-to-back: a read issued in the cycle after WDONE -> the address is accepted immediately, and slave_ready is 0 only during the WDONE cycle.
